// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave word RAM with programmable wait states, registered read return
// and a saturating access counter. Define AVS_BYTEEN_EN to add per-lane write enables.
module avalon_mem_responder #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
`ifdef AVS_BYTEEN_EN
    input  logic [3:0]  avs_byteenable,
`endif
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        avs_readdatavalid,
    output logic [15:0] access_count,
    output logic        proto_err
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word;
    logic [3:0]        lane_en;
    logic              req;
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              unused_addr;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  en);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

    // Upper address bits wrap the RAM; the byte offset is not used for word access.
    assign word        = avs_address[ADDR_W+1:2];
    assign unused_addr = ^{avs_address[31:ADDR_W+2], avs_address[1:0]};

`ifdef AVS_BYTEEN_EN
    assign lane_en = avs_byteenable;
`else
    assign lane_en = 4'hF;
`endif

    assign req    = avs_read | avs_write;
    assign accept = (state == S_ACK) && req;
    assign rd_acc = accept && avs_read;
    // A simultaneous read wins; the write half is discarded.
    assign wr_acc = accept && avs_write && !avs_read;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACK;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    state_nxt = S_ACK;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // waitrequest is registered from the next state so it is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= 4'd0;
            avs_waitrequest <= 1'b1;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            avs_waitrequest <= (state_nxt != S_ACK);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata      <= 32'd0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= rd_acc;
            if (rd_acc) avs_readdata <= mem[word];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            access_count <= 16'd0;
            proto_err    <= 1'b0;
        end else begin
            if (accept) access_count <= sat_inc16(access_count);
            if (avs_read && avs_write) proto_err <= 1'b1;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[word] <= merge_lanes(mem[word], avs_writedata, lane_en);
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Scoreboard bench for avalon_mem_responder (ADDR_W=6, WAIT_CYCLES=2); byte-lane
// cases are compiled in when AVS_BYTEEN_EN is defined.
module tb_avalon_mem_responder;

    localparam int AW    = 6;
    localparam int WC    = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] avs_address = 32'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
`ifdef AVS_BYTEEN_EN
    logic [3:0]  avs_byteenable = 4'hF;
`endif
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        avs_readdatavalid;
    logic [15:0] access_count;
    logic        proto_err;

    always #5 clk = ~clk;

    avalon_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
`ifdef AVS_BYTEEN_EN
        .avs_byteenable    (avs_byteenable),
`endif
        .avs_readdata      (avs_readdata),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdatavalid (avs_readdatavalid),
        .access_count      (access_count),
        .proto_err         (proto_err)
    );

    logic [31:0] model [DEPTH];
    logic [31:0] sb_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic        exp_perr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (avs_readdatavalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_readdatavalid", 32'd1, 32'd0);
            end else begin
                check_val("readdata", avs_readdata, sb_q.pop_front());
            end
        end
    end

    // Starts just after a rising edge (cycle 0); ends just after a rising edge.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, input string tag);
        int          w;
        int          cyc;
        bit          acc;
        logic [31:0] nv;
        w = int'(addr[AW+1:2]);
        if (rd) begin
            sb_q.push_back(model[w]);
        end else if (wr) begin
            nv = model[w];
`ifdef AVS_BYTEEN_EN
            for (int i = 0; i < 4; i++) begin
                if (be[i]) nv[8*i +: 8] = data[8*i +: 8];
            end
`else
            nv = data;
`endif
            model[w] = nv;
        end
        if (rd && wr) exp_perr = 1'b1;
        avs_address   = addr;
        avs_read      = rd;
        avs_write     = wr;
        avs_writedata = data;
`ifdef AVS_BYTEEN_EN
        avs_byteenable = be;
`endif
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc <= 40) begin
            @(negedge clk);
            if (avs_waitrequest === 1'b0) begin
                acc = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!acc) begin
            check_val({tag, "_timeout"}, 32'd0, 32'd1);
            avs_read  = 1'b0;
            avs_write = 1'b0;
            return;
        end
        check_val({tag, "_accept_cycle"}, 32'(cyc), 32'(WC + 1));
        @(posedge clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        exp_cnt   = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
        @(negedge clk);
        check_val({tag, "_rdv"}, 32'(avs_readdatavalid), 32'(rd));
        check_val({tag, "_waitreq_after"}, 32'(avs_waitrequest), 32'd1);
        check_val({tag, "_count"}, 32'(access_count), 32'(exp_cnt));
        check_val({tag, "_proto_err"}, 32'(proto_err), 32'(exp_perr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
        check_val("rst_readdata", avs_readdata, 32'd0);
        check_val("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        check_val("rst_count", 32'(access_count), 32'd0);
        check_val("rst_proto_err", 32'(proto_err), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int w = 0; w < DEPTH; w++) xfer(1'b0, 1'b1, 32'(w * 4), 32'd0, 4'hF, "preload");

        reset = 1'b1;
        exp_cnt = 16'd0;
        @(negedge clk);
        check_val("rst2_count", 32'(access_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset while a write sits in WAIT: the write must be dropped.
        avs_address   = 32'h4;
        avs_writedata = 32'h12345678;
        avs_write     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("rstwait_in_wait", 32'(avs_waitrequest), 32'd1);
        #1;
        reset     = 1'b1;
        avs_write = 1'b0;
        @(negedge clk);
        check_val("rstwait_waitreq", 32'(avs_waitrequest), 32'd1);
        check_val("rstwait_count", 32'(access_count), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        xfer(1'b0, 1'b1, 32'h8, 32'd584, 4'hF, "wr584");
        xfer(1'b1, 1'b0, 32'h8, 32'd0, 4'hF, "rd584");
        xfer(1'b1, 1'b0, 32'h4, 32'd0, 4'hF, "rd_dropped_wr");

        xfer(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, "wr_wrap");
        xfer(1'b1, 1'b0, 32'h0, 32'd0, 4'hF, "rd_wrap");

        xfer(1'b0, 1'b1, 32'h1B, 32'hCAFE0001, 4'hF, "wr_lowbits");
        xfer(1'b1, 1'b0, 32'h18, 32'd0, 4'hF, "rd_lowbits");

        xfer(1'b0, 1'b1, 32'h14, 32'h00000005, 4'hF, "wr_raw");
        xfer(1'b1, 1'b0, 32'h14, 32'd0, 4'hF, "rd_raw");

        // Abort: read dropped while in WAIT.
        avs_address = 32'h8;
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("abort_waitreq", 32'(avs_waitrequest), 32'd1);
        end
        @(posedge clk);
        #1;
        check_val("abort_count", 32'(access_count), 32'(exp_cnt));

        xfer(1'b0, 1'b1, 32'hC, 32'h0BADF00D, 4'hF, "wr_c");
        check_val("proto_err_clear", 32'(proto_err), 32'd0);
        xfer(1'b1, 1'b1, 32'hC, 32'd22, 4'hF, "rw_both");
        xfer(1'b1, 1'b0, 32'hC, 32'd0, 4'hF, "rd_c_after");

`ifdef AVS_BYTEEN_EN
        xfer(1'b0, 1'b1, 32'h10, 32'h11223344, 4'hF, "be_init");
        xfer(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, "be_0101");
        xfer(1'b1, 1'b0, 32'h10, 32'd0, 4'hF, "be_rd");
        xfer(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, "be_none");
        xfer(1'b1, 1'b0, 32'h10, 32'd0, 4'b0000, "be_rd2");
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("final_count", 32'(access_count), 32'(exp_cnt));
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
